hv_pwm_intb_encode: RTL and testbench

- HV-side encoder that drives the single isolated PWM/INTB return line to the LV die.
- The line normally carries the gate-wave feedback level.
- Fault-state changes on intb_n are sent as short inverted pulse frames: 1 pulse = INTB asserted (low), 3 pulses = INTB released (high).
- Frame timing is sized so the LV pulse-counting decoder (4..12-cycle pulse window, >12-cycle end-of-frame timeout) and its gate-wave glitch filter decode the line correctly.

---
 rtl/hv_pwm_intb_encode.sv | 198 +++++++++++++++++++
 tb/tb_hv_pwm_intb_encode.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hv_pwm_intb_encode.sv
`default_nettype none
// ============================================================================
// Module      : hv_pwm_intb_encode
// Description : HV-side encoder for the shared isolated PWM/INTB return line.
//               Idle traffic is the gate-wave feedback level, delayed one
//               clock. A change of the HV fault status (i_intb_n) is sent as
//               a frame of inverted pulses around the gate-wave level latched
//               at frame start:
//                 1 pulse  -> INTB asserted (low)
//                 3 pulses -> INTB released (high)
//               Every frame ends with a quiet tail. The LV pulse-counting
//               decoder uses this tail to detect end-of-frame. Its pulse
//               window is 4..12 cycles and its end-of-frame timeout is
//               more than 12 cycles.
//
// Parameters  : PULSE_CYC - inverted pulse width in clocks (5..11)
//               GAP_CYC   - inter-pulse gap at the latched level (5..11)
//               QUIET_CYC - tail at the latched level before live gwave
//                           resumes (>= 14)
//
// Ports       : i_clk           - block clock
//               i_rst_n         - asynchronous active-low reset
//               i_gwave         - gate-wave level to carry on the line
//               i_intb_n        - HV fault status, active low
//               o_hv_pwm_intb_n - encoded line to the isolator (registered)
//               o_busy          - high while a frame (incl. tail) is active
//               o_frame_done    - one-cycle pulse when a frame tail completes
//
// Revision    : 1.0 - initial release
// ============================================================================
module hv_pwm_intb_encode #(
  parameter int PULSE_CYC = 8,
  parameter int GAP_CYC   = 8,
  parameter int QUIET_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_gwave,
  input  logic i_intb_n,
  output logic o_hv_pwm_intb_n,
  output logic o_busy,
  output logic o_frame_done
);

  // Phase counter is sized for the longest phase so it never has to wrap.
  localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_PG > QUIET_CYC) ? MAX_PG : QUIET_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Each phase loads (length - 1) on entry and counts down to zero.
  localparam logic [CNT_W-1:0] c_pulse_ld = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] c_gap_ld   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] c_quiet_ld = CNT_W'(QUIET_CYC - 1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    QUIET = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_pulses_left;
  logic             r_sent_lvl;     // last fault level that was sent to LV
  logic             r_lat_gw;       // gate-wave level frozen for the frame
  logic             r_line;
  logic             r_busy;
  logic             r_frame_done;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_pulses_left_nxt;
  logic             w_sent_lvl_nxt;
  logic             w_lat_gw_nxt;
  logic             w_line_nxt;
  logic             w_frame_done_nxt;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == c_cnt_zero);

  // Next-state and counter logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_pulses_left_nxt = r_pulses_left;
    w_sent_lvl_nxt    = r_sent_lvl;
    w_lat_gw_nxt      = r_lat_gw;
    w_frame_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = c_cnt_zero;
        // A level comparison rather than an edge event. Any fault activity
        // during a frame collapses to its net effect, which is seen here.
        if (i_intb_n != r_sent_lvl) begin
          w_state_nxt       = PULSE;
          w_cnt_nxt         = c_pulse_ld;
          w_pulses_left_nxt = i_intb_n ? 2'd3 : 2'd1;
          w_sent_lvl_nxt    = i_intb_n;
          w_lat_gw_nxt      = i_gwave;
        end
      end

      PULSE: begin
        if (w_cnt_done) begin
          w_pulses_left_nxt = r_pulses_left - 2'd1;
          // A count of 1 or less means this was the last pulse. A corrupted
          // count of 0 therefore still terminates the frame.
          if (r_pulses_left > 2'd1) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = c_gap_ld;
          end else begin
            w_state_nxt = QUIET;
            w_cnt_nxt   = c_quiet_ld;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      GAP: begin
        if (w_cnt_done) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = c_pulse_ld;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      QUIET: begin
        if (w_cnt_done) begin
          w_state_nxt      = IDLE;
          w_cnt_nxt        = c_cnt_zero;
          w_frame_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = c_cnt_zero;
      end
    endcase
  end

  // The line level is decoded from the *next* state so that the registered
  // output changes in the same cycle as the state. The first pulse edge
  // therefore lands one clock after the fault change is seen, and live
  // gwave returns in the first IDLE cycle.
  always_comb begin
    w_line_nxt = i_gwave;
    case (w_state_nxt)
      PULSE:       w_line_nxt = ~w_lat_gw_nxt;
      GAP, QUIET:  w_line_nxt = w_lat_gw_nxt;
      default:     w_line_nxt = i_gwave;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= c_cnt_zero;
      r_pulses_left <= 2'd0;
      r_sent_lvl    <= 1'b1;
      r_lat_gw      <= 1'b1;
      r_line        <= 1'b1;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pulses_left <= w_pulses_left_nxt;
      r_sent_lvl    <= w_sent_lvl_nxt;
      r_lat_gw      <= w_lat_gw_nxt;
      r_line        <= w_line_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_frame_done  <= w_frame_done_nxt;
    end
  end

  assign o_hv_pwm_intb_n = r_line;
  assign o_busy          = r_busy;
  assign o_frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hv_pwm_intb_encode.sv
`default_nettype none
// ============================================================================
// Module      : tb_hv_pwm_intb_encode
// Description : Directed self-checking bench for hv_pwm_intb_encode with
//               default parameters (8/8/16). Inputs change and outputs are
//               sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hv_pwm_intb_encode;

  logic clk;
  logic rst_n;
  logic gwave;
  logic intb_n;
  logic line;
  logic busy;
  logic frame_done;

  int n_vec;
  int n_err;

  hv_pwm_intb_encode #(
    .PULSE_CYC (8),
    .GAP_CYC   (8),
    .QUIET_CYC (16)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_gwave         (gwave),
    .i_intb_n        (intb_n),
    .o_hv_pwm_intb_n (line),
    .o_busy          (busy),
    .o_frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Checks one full frame, cycle by cycle, after a fault change has been
  // presented at the preceding falling edge. k counts falling edges. At
  // edge k the line shows the value for cycle t+k. The cycle after the
  // tail shows live gwave and frame_done.
  // The task can also change intb_n at up to two points, and it can toggle
  // gwave every 3 cycles while the frame is running.
  task automatic check_frame(input logic gw, input bit rel,
                             input int c1_k, input logic c1_v,
                             input int c2_k, input logic c2_v,
                             input bit tog3);
    int   len;
    int   pos;
    bit   pulse;
    logic exp_line;
    len = rel ? 56 : 24;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      pos   = k - 1;
      pulse = rel ? ((pos < 40) && ((pos % 16) < 8)) : (pos < 8);
      if (k <= len) begin
        exp_line = pulse ? ~gw : gw;
        chk($sformatf("%s k=%0d line", rel ? "rel" : "ast", k), {31'd0, line}, {31'd0, exp_line});
        chk($sformatf("%s k=%0d busy", rel ? "rel" : "ast", k), {31'd0, busy}, 32'd1);
        chk($sformatf("%s k=%0d done", rel ? "rel" : "ast", k), {31'd0, frame_done}, 32'd0);
      end else begin
        chk($sformatf("%s end line", rel ? "rel" : "ast"), {31'd0, line}, {31'd0, gwave});
        chk($sformatf("%s end busy", rel ? "rel" : "ast"), {31'd0, busy}, 32'd0);
        chk($sformatf("%s end done", rel ? "rel" : "ast"), {31'd0, frame_done}, 32'd1);
      end
      if (k == c1_k) intb_n = c1_v;
      if (k == c2_k) intb_n = c2_v;
      if (tog3 && (k % 3 == 0) && (k <= len)) gwave = ~gwave;
    end
  endtask

  // The line must stay idle and follow gwave for n cycles.
  task automatic check_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, " line"}, {31'd0, line}, {31'd0, gwave});
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " done"}, {31'd0, frame_done}, 32'd0);
      if (k % 4 == 1) gwave = ~gwave;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    gwave  = 1'b0;
    intb_n = 1'b1;

    // Reset state: the line idles high regardless of gwave.
    repeat (3) @(negedge clk);
    chk("rst line", {31'd0, line}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst line", {31'd0, line}, 32'd0);
    chk("post-rst busy", {31'd0, busy}, 32'd0);
    check_idle("idle0", 6);

    // Assert frame with gwave=1: a low pulse for 8 cycles, then high.
    gwave = 1'b1;
    @(negedge clk);
    intb_n = 1'b0;
    check_frame(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Release frame with gwave=0: three high pulses.
    gwave = 1'b0;
    @(negedge clk);
    intb_n = 1'b1;
    check_frame(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    check_idle("idle1", 4);

    // Release during an assert frame: the assert frame completes, and a
    // release frame follows immediately after frame_done.
    gwave = 1'b1;
    @(negedge clk);
    intb_n = 1'b0;
    check_frame(1'b1, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0);
    check_frame(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    check_idle("idle2", 4);

    // A fault pulse that returns within the frame produces no second frame.
    intb_n = 1'b0;
    check_frame(gwave, 1'b0, 3, 1'b1, 6, 1'b0, 1'b0);
    check_idle("idle3", 30);

    // gwave toggles every 3 cycles during a release frame and is ignored.
    gwave  = 1'b0;
    @(negedge clk);
    intb_n = 1'b1;
    check_frame(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
    gwave = ~gwave;
    @(negedge clk);
    chk("gw follow line", {31'd0, line}, {31'd0, gwave});

    // Reset during the second gap of a release frame.
    gwave  = 1'b1;
    @(negedge clk);
    intb_n = 1'b0;
    check_frame(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    gwave  = 1'b0;
    @(negedge clk);
    intb_n = 1'b1;
    repeat (28) @(negedge clk);
    chk("2nd gap line", {31'd0, line}, 32'd0);
    chk("2nd gap busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst line", {31'd0, line}, 32'd1);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle("rst rel hi", 60);

    // Reset again, then release it with the fault asserted.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    gwave  = 1'b0;
    intb_n = 1'b0;
    rst_n  = 1'b1;
    check_frame(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    check_idle("final", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
